uart_tx_arbiter: RTL and testbench

- Round-robin scheduler sharing one UART transmitter (osdvu-style transmit / tx_byte / is_transmitting interface) among N_REQ byte-stream requesters.
- Grants are packet-atomic: the granted requester keeps the transmitter until it delivers a byte flagged LAST.
- Sits between on-chip message sources (status reporter, RX echo, debug dump) and the single UART instance in the top level.

---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic sharing of one UART transmitter among N_REQ byte streams.
// Optional feature macro UART_ARB_TAG_EN: each new grant first sends a tag byte {4'hA, owner}.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic               CLK_i,
  input  logic               RST_i,
  input  logic [N_REQ-1:0]   REQ_VALID_i,
  input  logic [8*N_REQ-1:0] REQ_DATA_i,
  input  logic [N_REQ-1:0]   REQ_LAST_i,
  output logic [N_REQ-1:0]   REQ_READY_o,
  output logic [N_REQ-1:0]   GRANT_o,
  output logic               UART_TRANSMIT_o,
  output logic [7:0]         UART_TX_BYTE_o,
  input  logic               UART_IS_TRANSMITTING_i,
  output logic               BUSY_o,
  output logic               ERR_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_PULSE      = 3'd2;
  localparam logic [2:0] S_WAIT_START = 3'd3;
  localparam logic [2:0] S_WAIT_END   = 3'd4;
`ifdef UART_ARB_TAG_EN
  localparam logic [2:0] S_TAG        = 3'd5;
`endif

  logic [2:0]       state_q,    state_d;
  logic [N_REQ-1:0] grant_q,    grant_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [7:0]       tx_byte_q,  tx_byte_d;
  logic             transmit_q, transmit_d;
  logic             last_q,     last_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             err_q,      err_d;
  logic             busy_q,     busy_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [SUM_W-1:0] scan_sum;
  logic [IDX_W-1:0] scan_idx;
  logic             accept;
  logic             byte_done;

  // Only the owner can be accepted, and only while the FSM waits for its next byte.
  assign accept      = (state_q == S_ISSUE) && REQ_VALID_i[owner_q];
  assign REQ_READY_o = accept ? grant_q : '0;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
      scan_idx = (scan_sum >= SUM_W'(N_REQ)) ? IDX_W'(scan_sum - SUM_W'(N_REQ))
                                             : IDX_W'(scan_sum);
      if (!win_found && REQ_VALID_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    tx_byte_d = tx_byte_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    byte_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
`ifdef UART_ARB_TAG_EN
          state_d          = S_TAG;
`else
          state_d          = S_ISSUE;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        tx_byte_d = {4'hA, 4'(owner_q)};
        last_d    = 1'b0;
        state_d   = S_PULSE;
      end
`endif
      S_ISSUE: begin
        if (accept) begin
          tx_byte_d = REQ_DATA_i[{owner_q, 3'b000} +: 8];
          last_d    = REQ_LAST_i[owner_q];
          state_d   = S_PULSE;
        end
      end
      S_PULSE: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (UART_IS_TRANSMITTING_i) begin
          state_d = S_WAIT_END;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // UART never started: flag it and carry on as if the byte went out.
          err_d     = 1'b1;
          byte_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_END: begin
        if (!UART_IS_TRANSMITTING_i) begin
          byte_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_done) begin
      if (last_q) begin
        grant_d  = '0;
        rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d  = S_IDLE;
      end else begin
        state_d  = S_ISSUE;
      end
    end

    transmit_d = (state_d == S_PULSE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      tx_byte_q  <= 8'h00;
      transmit_q <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_byte_q  <= tx_byte_d;
      transmit_q <= transmit_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign GRANT_o         = grant_q;
  assign UART_TRANSMIT_o = transmit_q;
  assign UART_TX_BYTE_o  = tx_byte_q;
  assign BUSY_o          = busy_q;
  assign ERR_o           = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random packet sets checked
// against a packet-level round-robin model of the expected UART byte stream.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int TMO      = 15;
  localparam int BUSY_LEN = 10;
  localparam int MAXB     = 64;
  localparam int MAXL     = 512;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           uart_transmit;
  logic [7:0]     uart_tx_byte;
  logic           uart_busy;
  logic           busy;
  logic           err;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TMO)) dut (
    .CLK_i                  (clk),
    .RST_i                  (rst),
    .REQ_VALID_i            (req_valid),
    .REQ_DATA_i             (req_data),
    .REQ_LAST_i             (req_last),
    .REQ_READY_o            (req_ready),
    .GRANT_o                (grant),
    .UART_TRANSMIT_o        (uart_transmit),
    .UART_TX_BYTE_o         (uart_tx_byte),
    .UART_IS_TRANSMITTING_i (uart_busy),
    .BUSY_o                 (busy),
    .ERR_o                  (err)
  );

  always #5 clk = ~clk;

  // Per-requester byte streams (written by the sequence, consumed by the driver).
  logic [7:0] sdat  [N][MAXB];
  logic       slast [N][MAXB];
  int         sgap  [N][MAXB];
  int         slen  [N];
  int         sptr  [N];
  int         gcnt  [N];
  int         rdy_cnt [N];
  logic [N-1:0] acc_pend;
  int         clr_gen, clr_seen;
  bit         uart_never;
  int         ubusy_cnt;

  logic [7:0]   log_byte  [MAXL];
  logic [N-1:0] log_grant [MAXL];
  int           log_cyc   [MAXL];
  int           nlog, bad_ready;

  // Reference model state.
  int         mptr [N];
  int         m_rr;
  logic [7:0] exp_byte [MAXL];
  int         exp_own  [MAXL];
  int         nexp;

  int total, bad, cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester drivers, UART model and output logger.
  always @(negedge clk) begin
    if (clr_seen != clr_gen) begin
      clr_seen  = clr_gen;
      nlog      = 0;
      bad_ready = 0;
      acc_pend  = '0;
      for (int k = 0; k < N; k++) begin
        sptr[k] = 0; gcnt[k] = 0; rdy_cnt[k] = 0;
      end
    end
    if (ubusy_cnt > 0) begin
      ubusy_cnt--;
      if (ubusy_cnt == 0) uart_busy = 1'b0;
    end
    if (rst !== 1'b0) begin
      acc_pend  = '0;
      uart_busy = 1'b0;
      ubusy_cnt = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (acc_pend[k]) begin
        sptr[k]++;
        gcnt[k] = (sptr[k] < slen[k]) ? sgap[k][sptr[k]] : 0;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (sptr[k] < slen[k] && gcnt[k] == 0) begin
        req_valid[k]      = 1'b1;
        req_data[8*k +: 8] = sdat[k][sptr[k]];
        req_last[k]       = slast[k][sptr[k]];
      end else begin
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
        if (gcnt[k] > 0) gcnt[k]--;
      end
    end
    #1;
    acc_pend = req_valid & req_ready;
    for (int k = 0; k < N; k++) if (acc_pend[k]) rdy_cnt[k]++;
    if ((req_ready & ~grant) != '0) bad_ready++;
    if (uart_transmit === 1'b1) begin
      if (nlog < MAXL) begin
        log_byte[nlog]  = uart_tx_byte;
        log_grant[nlog] = grant;
        log_cyc[nlog]   = cyc;
      end
      nlog++;
      if (!uart_never) begin
        uart_busy = 1'b1;
        ubusy_cnt = BUSY_LEN;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic clear_streams();
    for (int k = 0; k < N; k++) begin
      slen[k] = 0; mptr[k] = 0;
    end
    nexp = 0;
    clr_gen++;
    tick();
  endtask

  task automatic add_byte(input int k, input logic [7:0] d, input logic l, input int g);
    sdat[k][slen[k]]  = d;
    slast[k][slen[k]] = l;
    sgap[k][slen[k]]  = g;
    slen[k]++;
  endtask

  task automatic push_exp(input int k, input logic [7:0] b);
    if (nexp < MAXL) begin
      exp_byte[nexp] = b;
      exp_own[nexp]  = k;
    end
    nexp++;
  endtask

  // Whole packets, one per turn, in cyclic order starting at the model pointer.
  task automatic model_run();
    bit more = 1'b1;
    while (more) begin
      bit found = 1'b0;
      int k = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && mptr[(m_rr + i) % N] < slen[(m_rr + i) % N]) begin
          found = 1'b1;
          k     = (m_rr + i) % N;
        end
      end
      if (!found) begin
        more = 1'b0;
      end else begin
        bit lst = 1'b0;
`ifdef UART_ARB_TAG_EN
        push_exp(k, 8'hA0 | 8'(k));
`endif
        while (!lst) begin
          push_exp(k, sdat[k][mptr[k]]);
          lst = slast[k][mptr[k]];
          mptr[k]++;
        end
        m_rr = (k + 1) % N;
      end
    end
  endtask

  function automatic bit all_consumed();
    bit r = 1'b1;
    for (int k = 0; k < N; k++) if (sptr[k] < slen[k]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_done(input string name);
    int n = 0;
    while (!(all_consumed() && busy === 1'b0) && n < 5000) begin
      tick();
      n++;
    end
    chk({name, "_finished"}, 32'(n < 5000), 1);
    tick();
    tick();
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, nlog, nexp);
    for (int i = 0; i < nexp && i < nlog && i < MAXL; i++) begin
      chk($sformatf("%s_byte%0d", name, i), 32'(log_byte[i]), 32'(exp_byte[i]));
      chk($sformatf("%s_grant%0d", name, i), 32'(log_grant[i]), 32'(1) << exp_own[i]);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_grant"},    32'(grant), 0);
    chk({name, "_ready"},    32'(req_ready), 0);
    chk({name, "_transmit"}, 32'(uart_transmit), 0);
    chk({name, "_txbyte"},   32'(uart_tx_byte), 0);
    chk({name, "_busy"},     32'(busy), 0);
    chk({name, "_err"},      32'(err), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_streams();
    tick();
    rst = 1'b0;
    tick();
    m_rr = 0;
  endtask

  initial begin
    int n;
    int t0;
    rst        = 1'b1;
    uart_never = 1'b0;
    tick();
    tick();
    check_reset("rst0");
    rst = 1'b0;
    tick();

    // Single requester, three-byte packet.
    clear_streams();
    m_rr = 0;
    add_byte(1, 8'h48, 1'b0, 0);
    add_byte(1, 8'h69, 1'b0, 0);
    add_byte(1, 8'h0A, 1'b1, 0);
    model_run();
    wait_done("single");
    check_log("single");
    chk("single_ready_cnt", rdy_cnt[1], 3);
    chk("single_busy_end", 32'(busy), 0);
    chk("single_grant_end", 32'(grant), 0);

    // Pointer now past req1: req3 must be served before req0.
    clear_streams();
    add_byte(0, 8'hB0, 1'b1, 0);
    add_byte(3, 8'hB3, 1'b1, 0);
    model_run();
    wait_done("ptr2");
    check_log("ptr2");

    // All four at once after reset.
    do_reset();
    for (int k = 0; k < N; k++) add_byte(k, 8'hA0 + 8'(k), 1'b1, 0);
    model_run();
    wait_done("all4");
    check_log("all4");

    // Packet lock: req2 stalls mid-packet while req0 waits.
    clear_streams();
    add_byte(2, 8'h31, 1'b0, 0);
    add_byte(2, 8'h32, 1'b0, 50);
    add_byte(2, 8'h33, 1'b1, 0);
    model_run();
    n = 0;
    while (grant !== 4'b0100 && n < 200) begin tick(); n++; end
    chk("lock_grant_seen", 32'(grant), 32'h4);
    add_byte(0, 8'h40, 1'b1, 0);
    model_run();
    repeat (25) tick();
    chk("lock_grant_mid", 32'(grant), 32'h4);
    chk("lock_req0_ready_mid", rdy_cnt[0], 0);
    wait_done("lock");
    check_log("lock");
    chk("lock_foreign_ready", bad_ready, 0);

    // Start timeout: the UART never raises busy.
    clear_streams();
    uart_never = 1'b1;
    add_byte(0, 8'h11, 1'b0, 0);
    add_byte(0, 8'h22, 1'b1, 0);
    model_run();
    n = 0;
    while (nlog < 1 && n < 200) begin tick(); n++; end
    chk("tmo_pulse_seen", 32'(nlog >= 1), 1);
    t0 = log_cyc[0];
    n = 0;
    while (err !== 1'b1 && n < 200) begin tick(); n++; end
    chk("tmo_err_rise", 32'(err), 1);
    chk("tmo_err_delay", cyc - t0, TMO + 1);
    wait_done("tmo");
    check_log("tmo");
    chk("tmo_err_sticky", 32'(err), 1);
    uart_never = 1'b0;

    // Reset while a byte is on the wire.
    clear_streams();
    add_byte(2, 8'hC1, 1'b0, 0);
    add_byte(2, 8'hC2, 1'b0, 0);
    add_byte(2, 8'hC3, 1'b1, 0);
    n = 0;
    while (!(uart_busy === 1'b1 && grant === 4'b0100) && n < 200) begin tick(); n++; end
    chk("rmid_in_byte", 32'(uart_busy === 1'b1 && grant === 4'b0100), 1);
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    check_reset("rmid");
    tick();
    clear_streams();
    rst = 1'b0;
    tick();
    m_rr = 0;
    add_byte(0, 8'hD0, 1'b1, 0);
    add_byte(3, 8'hD3, 1'b1, 0);
    model_run();
    wait_done("rpost");
    check_log("rpost");

`ifdef UART_ARB_TAG_EN
    clear_streams();
    add_byte(3, 8'h55, 1'b1, 0);
    model_run();
    wait_done("tag");
    check_log("tag");
    chk("tag_first", 32'(log_byte[0]), 32'hA3);
    chk("tag_second", 32'(log_byte[1]), 32'h55);
    chk("tag_ready_once", rdy_cnt[3], 1);
`endif

    // Random packet sets with mid-packet stalls.
    for (int r = 0; r < 4; r++) begin
      clear_streams();
      for (int k = 0; k < N; k++) begin
        int np = int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) begin
          int len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++)
            add_byte(k, 8'($urandom), 1'(b == len - 1), (b == 0) ? 0 : int'($urandom_range(0, 3)));
        end
      end
      model_run();
      wait_done($sformatf("rnd%0d", r));
      check_log($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_foreign_ready", r), bad_ready, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
